// File: rtl/l1_cache_dm.sv
// l1_cache_dm: parametrised direct-mapped, write-through L1 cache between a CPU memory port
// and the SDRAM arbiter. Addresses at or above CACHEABLE_LIMIT bypass the cache
// combinationally. Lines are one word; a hardware sweep clears every valid bit after reset
// and on a flush request.
//
// Build option: define L1C_WRITE_ALLOCATE_EN to write {tag, data} into the line on write
// completion (write-allocate). Left undefined, a write only invalidates its line.
module l1_cache_dm #(
    parameter int unsigned ADDR_BITS       = 24,
    parameter int unsigned INDEX_BITS      = 10,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter logic [31:0] CACHEABLE_LIMIT = 32'h0080_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    // CPU side
    input  logic [31:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    input  logic                  cpu_we,
    input  logic                  cpu_start,
    output logic [DATA_WIDTH-1:0] cpu_q,
    output logic                  cpu_done,
    input  logic                  flush,
    output logic                  flush_busy,
    // SDRAM side
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  mem_start,
    input  logic [DATA_WIDTH-1:0] mem_q,
    input  logic                  mem_done
);

    localparam int unsigned TAG_BITS  = ADDR_BITS - INDEX_BITS;
    localparam int unsigned DEPTH     = 1 << INDEX_BITS;
    localparam int unsigned LINE_BITS = TAG_BITS + DATA_WIDTH;

    typedef enum logic [2:0] {
        StSweep,
        StIdle,
        StLookup,
        StCompare,
        StMiss,
        StWrite
    } state_e;

    state_e                  state_q, state_d;
    logic [INDEX_BITS-1:0]   sweep_idx_q, sweep_idx_d;
    logic                    flush_pend_q, flush_pend_d;
    logic                    req_pend_q, req_pend_d;
    logic                    start_prev_q, start_prev_d;
    logic                    uncache_prev_q, uncache_prev_d;

    // Latched request; tag and index always come from here, never from live cpu_addr
    logic [ADDR_BITS-1:0]    lat_addr_q, lat_addr_d;
    logic [DATA_WIDTH-1:0]   lat_data_q, lat_data_d;
    logic                    lat_we_q, lat_we_d;

    // Registered CPU/SDRAM outputs used in cached mode
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    done_q, done_d;
    logic [31:0]             mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
    logic                    mem_we_q, mem_we_d;
    logic                    mem_start_q, mem_start_d;

    // {tag, data} storage with a synchronous read port
    logic [LINE_BITS-1:0]    line_ram [DEPTH];
    logic [LINE_BITS-1:0]    ram_rdata_q;
    logic                    ram_we;
    logic [INDEX_BITS-1:0]   ram_widx;
    logic [LINE_BITS-1:0]    ram_wdata;

    // Valid bits: one write port, one registered read
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic                    valid_rd_q;
    logic                    valid_we;
    logic [INDEX_BITS-1:0]   valid_widx;
    logic                    valid_wval;

    logic                    cacheable;
    logic                    start_rise;
    logic [INDEX_BITS-1:0]   lat_idx;
    logic [TAG_BITS-1:0]     lat_tag;
    logic                    hit;

    assign cacheable  = (cpu_addr < CACHEABLE_LIMIT);
    assign start_rise = cpu_start & ~start_prev_q;
    assign lat_idx    = lat_addr_q[INDEX_BITS-1:0];
    assign lat_tag    = lat_addr_q[ADDR_BITS-1:INDEX_BITS];
    assign hit        = valid_rd_q && (ram_rdata_q[LINE_BITS-1:DATA_WIDTH] == lat_tag);

    // Next-state, request bookkeeping and storage write-port control
    always_comb begin
        state_d        = state_q;
        sweep_idx_d    = sweep_idx_q;
        flush_pend_d   = flush_pend_q;
        req_pend_d     = req_pend_q;
        start_prev_d   = cpu_start;
        uncache_prev_d = ~cacheable;
        lat_addr_d     = lat_addr_q;
        lat_data_d     = lat_data_q;
        lat_we_d       = lat_we_q;
        rd_data_d      = rd_data_q;
        done_d         = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_data_d     = mem_data_q;
        mem_we_d       = mem_we_q;
        mem_start_d    = mem_start_q;
        ram_we         = 1'b0;
        ram_widx       = lat_idx;
        ram_wdata      = {lat_tag, lat_data_q};
        valid_we       = 1'b0;
        valid_widx     = lat_idx;
        valid_wval     = 1'b0;

        // A flush outside IDLE waits until the FSM gets back there
        if (flush && (state_q != StIdle)) begin
            flush_pend_d = 1'b1;
        end

        unique case (state_q)
            StSweep: begin
                valid_we    = 1'b1;
                valid_widx  = sweep_idx_q;
                valid_wval  = 1'b0;
                sweep_idx_d = sweep_idx_q + INDEX_BITS'(1);
                if (start_rise) begin
                    req_pend_d = 1'b1;
                end
                if (&sweep_idx_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (flush_pend_q || flush) begin
                    // Sweep wins over a request arriving in the same cycle
                    state_d      = StSweep;
                    flush_pend_d = 1'b0;
                    sweep_idx_d  = '0;
                    if (start_rise) begin
                        req_pend_d = 1'b1;
                    end
                end else if (cacheable && cpu_start &&
                             (start_rise || uncache_prev_q || req_pend_q)) begin
                    req_pend_d = 1'b0;
                    lat_addr_d = cpu_addr[ADDR_BITS-1:0];
                    lat_data_d = cpu_data;
                    lat_we_d   = cpu_we;
                    if (cpu_we) begin
                        state_d     = StWrite;
                        mem_start_d = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cpu_addr;
                        mem_data_d  = cpu_data;
                    end else begin
                        state_d = StLookup;
                    end
                end else if (!cpu_start) begin
                    req_pend_d = 1'b0;
                end
            end
            StLookup: begin
                state_d = StCompare;
            end
            StCompare: begin
                if (hit) begin
                    rd_data_d = ram_rdata_q[DATA_WIDTH-1:0];
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end else begin
                    mem_start_d = 1'b1;
                    mem_we_d    = lat_we_q;
                    mem_addr_d  = 32'(lat_addr_q);
                    state_d     = StMiss;
                end
            end
            StMiss: begin
                if (mem_done) begin
                    mem_start_d = 1'b0;
                    ram_we      = 1'b1;
                    ram_wdata   = {lat_tag, mem_q};
                    valid_we    = 1'b1;
                    valid_wval  = 1'b1;
                    rd_data_d   = mem_q;
                    done_d      = 1'b1;
                    state_d     = StIdle;
                end
            end
            StWrite: begin
                if (mem_done) begin
                    mem_start_d = 1'b0;
                    mem_we_d    = 1'b0;
                    done_d      = 1'b1;
                    state_d     = StIdle;
`ifdef L1C_WRITE_ALLOCATE_EN
                    ram_we      = 1'b1;
                    ram_wdata   = {lat_tag, lat_data_q};
                    valid_we    = 1'b1;
                    valid_wval  = 1'b1;
`else
                    valid_we    = 1'b1;
                    valid_wval  = 1'b0;
`endif
                end
            end
            default: begin
                state_d = StSweep;
            end
        endcase
    end

    // Valid-bit array next state: a single write port
    always_comb begin
        valid_d = valid_q;
        if (valid_we) begin
            valid_d[valid_widx] = valid_wval;
        end
    end

    // Control and output registers; reset aborts any transaction and restarts the sweep
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StSweep;
            sweep_idx_q    <= '0;
            flush_pend_q   <= 1'b0;
            req_pend_q     <= 1'b0;
            start_prev_q   <= 1'b0;
            uncache_prev_q <= 1'b0;
            lat_addr_q     <= '0;
            lat_data_q     <= '0;
            lat_we_q       <= 1'b0;
            rd_data_q      <= '0;
            done_q         <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            mem_we_q       <= 1'b0;
            mem_start_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sweep_idx_q    <= sweep_idx_d;
            flush_pend_q   <= flush_pend_d;
            req_pend_q     <= req_pend_d;
            start_prev_q   <= start_prev_d;
            uncache_prev_q <= uncache_prev_d;
            lat_addr_q     <= lat_addr_d;
            lat_data_q     <= lat_data_d;
            lat_we_q       <= lat_we_d;
            rd_data_q      <= rd_data_d;
            done_q         <= done_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
            mem_we_q       <= mem_we_d;
            mem_start_q    <= mem_start_d;
        end
    end

    // Valid bits have no reset; the post-reset sweep clears them
    always_ff @(posedge clk) begin
        valid_q    <= valid_d;
        valid_rd_q <= valid_q[lat_idx];
    end

    // Tag/data RAM: one write port, synchronous read at the latched index
    always_ff @(posedge clk) begin
        if (ram_we) begin
            line_ram[ram_widx] <= ram_wdata;
        end
        ram_rdata_q <= line_ram[lat_idx];
    end

    // Uncacheable addresses connect CPU and SDRAM straight through
    always_comb begin
        if (cacheable) begin
            mem_addr  = mem_addr_q;
            mem_data  = mem_data_q;
            mem_we    = mem_we_q;
            mem_start = mem_start_q;
            cpu_q     = rd_data_q;
            cpu_done  = done_q;
        end else begin
            mem_addr  = cpu_addr;
            mem_data  = cpu_data;
            mem_we    = cpu_we;
            mem_start = cpu_start;
            cpu_q     = mem_q;
            cpu_done  = mem_done;
        end
    end

    assign flush_busy = (state_q == StSweep);

endmodule

// File: tb/tb_l1_cache_dm.sv
// tb_l1_cache_dm: directed table, flush/reset corner sequences and a randomized run of
// l1_cache_dm against a behavioural cache model and an SDRAM responder.
module tb_l1_cache_dm;

    localparam logic [31:0] LIMIT = 32'h0080_0000;
    localparam int          DEPTH = 1024;

    logic        clk, reset;
    logic [31:0] cpu_addr, cpu_data, cpu_q;
    logic        cpu_we, cpu_start, cpu_done;
    logic        flush, flush_busy;
    logic [31:0] mem_addr, mem_data, mem_q;
    logic        mem_we, mem_start, mem_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_done_cyc = 0;

    l1_cache_dm dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_we     (cpu_we),
        .cpu_start  (cpu_start),
        .cpu_q      (cpu_q),
        .cpu_done   (cpu_done),
        .flush      (flush),
        .flush_busy (flush_busy),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_start  (mem_start),
        .mem_q      (mem_q),
        .mem_done   (mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Background contents of SDRAM for never-written words
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    // SDRAM responder
    logic [31:0] sdram [logic [31:0]];

    function automatic logic [31:0] sd_rd(input logic [31:0] a);
        return sdram.exists(a) ? sdram[a] : word_of(a);
    endfunction

    initial begin
        int lat;
        mem_done = 1'b0;
        mem_q    = '0;
        forever begin
            @(posedge clk); #2;
            if (mem_start === 1'b1 && !reset) begin
                lat = $urandom_range(0, 3);
                repeat (lat) begin
                    @(posedge clk); #2;
                end
                if (mem_we) sdram[mem_addr] = mem_data;
                else        mem_q = sd_rd(mem_addr);
                mem_done      = 1'b1;
                last_done_cyc = cyc;
                @(posedge clk); #2;
                mem_done = 1'b0;
            end
        end
    end

    // Reference model: backing memory plus per-index valid/tag
    logic [31:0] ref_mem [logic [31:0]];
    bit          ref_v [DEPTH];
    logic [13:0] ref_t [DEPTH];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : word_of(a);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) ref_v[i] = 1'b0;
    endfunction

    // Returns expected read data; st = number of SDRAM requests expected
    function automatic logic [31:0] model_access(input logic [31:0] a, input logic w,
                                                 input logic [31:0] d, output int st);
        int          idx;
        logic [13:0] tag;
        if (a >= LIMIT) begin
            st = 1;
            if (w) ref_mem[a] = d;
            return ref_rd(a);
        end
        idx = int'(a[9:0]);
        tag = a[23:10];
        if (w) begin
            st = 1;
            ref_mem[a] = d;
`ifdef L1C_WRITE_ALLOCATE_EN
            ref_v[idx] = 1'b1;
            ref_t[idx] = tag;
`else
            ref_v[idx] = 1'b0;
`endif
            return d;
        end
        st = (ref_v[idx] && ref_t[idx] == tag) ? 0 : 1;
        ref_v[idx] = 1'b1;
        ref_t[idx] = tag;
        return ref_rd(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=timeout required=response", name);
    endtask

    // Counts samples with flush_busy high, starting with the current sample
    task automatic wait_sweep(output int n);
        n = 0;
        while (flush_busy === 1'b1 && n < 3000) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    // One CPU transaction; returns after the sample following cpu_done
    task automatic run_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input bit pulse_flush, output logic [31:0] q,
                              output int starts, output int first_start, output int done_at);
        logic prev_ms;
        bit   pt;
        int   n;
        pt = (a >= LIMIT);
        @(posedge clk); #1;
        cpu_addr  = a;
        cpu_we    = w;
        cpu_data  = d;
        cpu_start = 1'b1;
        prev_ms = 1'b0; starts = 0; first_start = -1; done_at = -1; n = 0; q = '0;
        while (done_at < 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (pt) begin
                check("pt_addr", mem_addr, cpu_addr);
                check("pt_start", 32'(mem_start), 32'(cpu_start));
                check("pt_we", 32'(mem_we), 32'(cpu_we));
                check("pt_data", mem_data, cpu_data);
                check("pt_done", 32'(cpu_done), 32'(mem_done));
                check("pt_q", cpu_q, mem_q);
            end
            if (mem_start && !prev_ms) begin
                starts++;
                if (first_start < 0) first_start = n;
            end
            prev_ms = mem_start;
            flush = pulse_flush && (first_start == n);
            if (cpu_done) begin
                done_at = n;
                q = cpu_q;
                if (!pt && starts > 0) check("done_after_mem_done", cyc, last_done_cyc + 1);
            end
        end
        cpu_start = 1'b0;
        flush     = 1'b0;
        if (done_at < 0) fail_now("cpu_done_timeout");
        @(posedge clk); #1;
        check("done_one_cycle", 32'(cpu_done), 32'd0);
    endtask

    task automatic access_check(input string tag, input logic [31:0] a, input logic w,
                                input logic [31:0] d, input int exp_st,
                                input logic [31:0] exp_q, input bit pulse_flush);
        logic [31:0] q;
        int          st, fs, dn;
        run_access(a, w, d, pulse_flush, q, st, fs, dn);
        check({tag, "_starts"}, st, exp_st);
        if (!w) check({tag, "_rdata"}, q, exp_q);
        if (a < LIMIT) begin
            if (exp_st == 0)  check({tag, "_hit_lat"}, dn, 3);
            else if (w)       check({tag, "_wr_start_lat"}, fs, 1);
            else              check({tag, "_miss_start_lat"}, fs, 3);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          exp_starts;
        logic [31:0] exp_q;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int          n, st;
        logic [31:0] a, d, e;
        logic        w;
        logic [9:0]  idx_tab [4];

        reset = 1'b1; flush = 1'b0;
        cpu_addr = '0; cpu_data = '0; cpu_we = 1'b0; cpu_start = 1'b0;
        sdram[32'h123]   = 32'hDEAD_BEEF;
        ref_mem[32'h123] = 32'hDEAD_BEEF;

        // Reset values and post-reset sweep length
        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_q", cpu_q, 32'd0);
        check("rst_cpu_done", 32'(cpu_done), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_start", 32'(mem_start), 32'd0);
        check("rst_flush_busy", 32'(flush_busy), 32'd1);
        reset = 1'b0;
        wait_sweep(n);
        check("sweep_len_reset", n, DEPTH);
        model_clear();

        // Directed table
        vecs[0] = '{32'h0000_0123, 1'b0, 32'h0, 1, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0123, 1'b0, 32'h0, 0, 32'hDEAD_BEEF};
        vecs[2] = '{32'h0000_0523, 1'b0, 32'h0, 1, word_of(32'h523)};
        vecs[3] = '{32'h0000_0123, 1'b0, 32'h0, 1, 32'hDEAD_BEEF};
        vecs[4] = '{32'h0000_0040, 1'b1, 32'h1234_5678, 1, 32'h0};
`ifdef L1C_WRITE_ALLOCATE_EN
        vecs[5] = '{32'h0000_0040, 1'b0, 32'h0, 0, 32'h1234_5678};
`else
        vecs[5] = '{32'h0000_0040, 1'b0, 32'h0, 1, 32'h1234_5678};
`endif
        vecs[6] = '{32'h0000_0040, 1'b0, 32'h0, 0, 32'h1234_5678};
        vecs[7] = '{32'h0080_0010, 1'b0, 32'h0, 1, word_of(32'h80_0010)};
        vecs[8] = '{32'h0080_0010, 1'b1, 32'hAABB_CCDD, 1, 32'h0};
        vecs[9] = '{32'h0080_0010, 1'b0, 32'h0, 1, 32'hAABB_CCDD};
        for (int i = 0; i < 10; i++) begin
            e = model_access(vecs[i].addr, vecs[i].we, vecs[i].wdata, st);
            access_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we, vecs[i].wdata,
                         vecs[i].exp_starts, vecs[i].exp_q, 1'b0);
        end

        // Flush during an outstanding miss: miss completes, then a full sweep
        e = model_access(32'h777, 1'b0, 32'h0, st);
        access_check("flush_miss", 32'h777, 1'b0, 32'h0, st, e, 1'b1);
        check("flush_sweep_follows", 32'(flush_busy), 32'd1);
        wait_sweep(n);
        check("sweep_len_flush", n, DEPTH);
        model_clear();
        e = model_access(32'h123, 1'b0, 32'h0, st);
        access_check("post_flush_123", 32'h123, 1'b0, 32'h0, 1, e, 1'b0);
        e = model_access(32'h040, 1'b0, 32'h0, st);
        access_check("post_flush_040", 32'h040, 1'b0, 32'h0, 1, e, 1'b0);

        // Randomized traffic against the model
        idx_tab = '{10'h000, 10'h001, 10'h155, 10'h3FF};
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) a = LIMIT + 32'($urandom_range(0, 3));
            else a = (32'($urandom_range(0, 3)) << 10) | 32'(idx_tab[$urandom_range(0, 3)]);
            w = ($urandom_range(0, 3) == 0);
            d = $urandom;
            e = model_access(a, w, d, st);
            access_check("rand", a, w, d, st, e, 1'b0);
        end

        // Reset while a miss is outstanding
        @(posedge clk); #1;
        cpu_addr = 32'h2AB; cpu_we = 1'b0; cpu_start = 1'b1;
        n = 0;
        while (mem_start !== 1'b1 && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        if (mem_start !== 1'b1) fail_now("reset_miss_no_start");
        reset = 1'b1; cpu_start = 1'b0;
        @(posedge clk); #1;
        check("reset_miss_mem_start", 32'(mem_start), 32'd0);
        check("reset_miss_flush_busy", 32'(flush_busy), 32'd1);
        reset = 1'b0;
        wait_sweep(n);
        check("sweep_len_reset_miss", n, DEPTH);
        model_clear();
        e = model_access(32'h2AB, 1'b0, 32'h0, st);
        access_check("post_reset_2ab", 32'h2AB, 1'b0, 32'h0, 1, e, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
